ysyx_24070016_ifetch: RTL and testbench

Instruction-fetch stage that replaces the DPI-C fetch path. It holds the fetch PC and issues one read at a time to instruction memory over a valid/ready request/response pair. Each returned word is registered and presented to the decode stage (IDU) with a valid/ready handshake. Next-PC redirects (branches, jumps, mtvec/mepc traps) arrive from the execute-side next-PC logic.

---
 rtl/ysyx_24070016_pkg.sv | 13 +
 rtl/ysyx_24070016_ifetch_perf.sv | 21 ++
 rtl/ysyx_24070016_ifetch.sv | 127 ++++++++++++
 tb/tb_ysyx_24070016_ifetch.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_24070016_pkg.sv
// Shared types and constants for the ysyx_24070016 instruction-fetch stage.
package ysyx_24070016_pkg;

   typedef enum logic [1:0] {
      REQ  = 2'd0,
      WAIT = 2'd1,
      HOLD = 2'd2
   } fetch_state_e;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
   localparam logic [31:0] PC_STEP          = 32'd4;

endpackage

// File: rtl/ysyx_24070016_ifetch_perf.sv
// Fetch performance counters: request handshakes and cycles spent waiting on memory.
module ysyx_24070016_ifetch_perf (
   input  logic        clk,
   input  logic        rst,
   input  logic        fetch_fire,
   input  logic        in_wait,
   output logic [31:0] fetch_cnt,
   output logic [31:0] wait_cyc
);

   always_ff @(posedge clk) begin
      if (!rst) begin
         fetch_cnt <= '0;
         wait_cyc  <= '0;
      end else begin
         if (fetch_fire) fetch_cnt <= fetch_cnt + 32'd1;
         if (in_wait)    wait_cyc  <= wait_cyc + 32'd1;
      end
   end

endmodule

// File: rtl/ysyx_24070016_ifetch.sv
// Instruction fetch: one outstanding memory read, registered word handed to IDU.
// Optional counters are built only when YSYX_24070016_IFETCH_PERF_EN is defined.
//
// state | meaning
// REQ   | request pc from memory (misaligned pc raises a fault instead)
// WAIT  | request accepted, waiting for rsp_valid (drop = discard it)
// HOLD  | instruction presented to IDU until consumed or redirected
module ysyx_24070016_ifetch
   import ysyx_24070016_pkg::*;
#(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            req_valid,
   input  logic            req_ready,
   output logic [XLEN-1:0] req_addr,
   input  logic            rsp_valid,
   input  logic [XLEN-1:0] rsp_data,
   input  logic            rsp_err,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_pc,
   output logic [XLEN-1:0] out_inst,
   output logic            out_err,
   output logic [31:0]     perf_fetch_cnt,
   output logic [31:0]     perf_wait_cyc
);

   fetch_state_e    state;
   logic [XLEN-1:0] pc;
   logic            drop;
   logic            misaligned;
   logic            req_fire;
   logic            out_fire;

   assign misaligned = |pc[1:0];
   assign req_valid  = (state == REQ) && !misaligned;
   assign req_addr   = pc;
   assign req_fire   = req_valid && req_ready;
   assign out_fire   = out_valid && out_ready;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= REQ;
         pc        <= RESET_PC;
         drop      <= 1'b0;
         out_valid <= 1'b0;
         out_pc    <= '0;
         out_inst  <= '0;
         out_err   <= 1'b0;
      end else begin
         case (state)
            REQ: begin
               if (redirect_valid) begin
                  pc <= redirect_pc;
                  if (req_fire) begin
                     state <= WAIT;
                     drop  <= 1'b1;
                  end
               end else if (misaligned) begin
                  out_valid <= 1'b1;
                  out_err   <= 1'b1;
                  out_inst  <= '0;
                  out_pc    <= pc;
                  state     <= HOLD;
               end else if (req_fire) begin
                  state <= WAIT;
               end
            end
            WAIT: begin
               // A redirect orphans the in-flight read; its response must still be absorbed.
               if (redirect_valid) begin
                  pc <= redirect_pc;
                  if (rsp_valid) begin
                     drop  <= 1'b0;
                     state <= REQ;
                  end else begin
                     drop <= 1'b1;
                  end
               end else if (rsp_valid) begin
                  if (drop) begin
                     drop  <= 1'b0;
                     state <= REQ;
                  end else begin
                     out_valid <= 1'b1;
                     out_inst  <= rsp_data;
                     out_pc    <= pc;
                     out_err   <= rsp_err;
                     state     <= HOLD;
                  end
               end
            end
            HOLD: begin
               if (redirect_valid) begin
                  pc        <= redirect_pc;
                  out_valid <= 1'b0;
                  state     <= REQ;
               end else if (out_fire) begin
                  pc        <= pc + XLEN'(PC_STEP);
                  out_valid <= 1'b0;
                  state     <= REQ;
               end
            end
            default: state <= REQ;
         endcase
      end
   end

`ifdef YSYX_24070016_IFETCH_PERF_EN
   ysyx_24070016_ifetch_perf u_perf (
      .clk        (clk),
      .rst        (rst),
      .fetch_fire (req_fire),
      .in_wait    (state == WAIT),
      .fetch_cnt  (perf_fetch_cnt),
      .wait_cyc   (perf_wait_cyc)
   );
`else
   assign perf_fetch_cnt = '0;
   assign perf_wait_cyc  = '0;
`endif

endmodule

// File: tb/tb_ysyx_24070016_ifetch.sv
// Bench for ysyx_24070016_ifetch: vector table, directed corner sequences, random run vs. a PC-level model.
module tb_ysyx_24070016_ifetch;
   localparam logic [31:0] RST_PC = 32'h8000_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic        rsp_valid;
   logic [31:0] rsp_data;
   logic        rsp_err;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [31:0] out_inst;
   logic        out_err;
   logic [31:0] perf_fetch_cnt;
   logic [31:0] perf_wait_cyc;

   ysyx_24070016_ifetch dut (
      .clk            (clk),
      .rst            (rst),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_addr       (req_addr),
      .rsp_valid      (rsp_valid),
      .rsp_data       (rsp_data),
      .rsp_err        (rsp_err),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_pc         (out_pc),
      .out_inst       (out_inst),
      .out_err        (out_err),
      .perf_fetch_cnt (perf_fetch_cnt),
      .perf_wait_cyc  (perf_wait_cyc)
   );

   always #5 clk = ~clk;

   int          errors = 0;
   int          checks = 0;
   logic [31:0] model_pc;
   logic        mem_busy;
   logic [31:0] mem_addr;
   int          mem_cnt;
   int          n_fire;
   int          n_cons;

   typedef struct {
      logic        rr;
      logic        orr;
      logic        exp_req_valid;
      logic [31:0] exp_req_addr;
      logic        exp_out_valid;
      logic [31:0] exp_out_pc;
   } vec_t;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h1357_9bdf;
   endfunction

   function automatic logic mem_bad(input logic [31:0] a);
      return a[7:2] == 6'h04;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_b(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   // One clock: check against the model, drive inputs, advance memory and model, step.
   task automatic cycle(input logic rr, input logic orr, input logic rv,
                        input logic [31:0] rpc, input int lat);
      if (req_valid) begin
         chk("req_addr", req_addr, model_pc);
         chk("req_align", {30'b0, req_addr[1:0]}, 32'd0);
      end
      req_ready      = rr;
      out_ready      = orr;
      redirect_valid = rv;
      redirect_pc    = rpc;
      if (mem_busy && mem_cnt == 0) begin
         rsp_valid = 1'b1;
         rsp_data  = mem_word(mem_addr);
         rsp_err   = mem_bad(mem_addr);
         mem_busy  = 1'b0;
      end else begin
         rsp_valid = 1'b0;
         rsp_data  = $urandom;
         rsp_err   = 1'($urandom_range(0, 1));
         if (mem_busy) mem_cnt--;
      end
      if (req_valid && rr) begin
         mem_busy = 1'b1;
         mem_addr = req_addr;
         mem_cnt  = lat;
         n_fire++;
      end
      if (out_valid && orr) begin
         chk("out_pc", out_pc, model_pc);
         if (model_pc[1:0] != 2'b00) begin
            chk("out_inst_mis", out_inst, 32'd0);
            chk_b("out_err_mis", out_err, 1'b1);
         end else begin
            chk("out_inst", out_inst, mem_word(model_pc));
            chk_b("out_err", out_err, mem_bad(model_pc));
         end
         n_cons++;
         model_pc = rv ? rpc : model_pc + 32'd4;
      end else if (rv) begin
         model_pc = rpc;
      end
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      req_ready = 1'b0; out_ready = 1'b0;
      redirect_valid = 1'b0; redirect_pc = '0;
      rsp_valid = 1'b0; rsp_data = '0; rsp_err = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      mem_busy = 1'b0; mem_cnt = 0; model_pc = RST_PC;
      rst = 1'b1;
   endtask

   task automatic wait_out(input int lat, input string name);
      int k = 0;
      while (!out_valid && k < 30) begin
         cycle(1'b1, 1'b0, 1'b0, 32'd0, lat);
         k++;
      end
      if (!out_valid) chk_b({name, "_timeout"}, 1'b0, 1'b1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vec_t        vecs[9];
      logic [31:0] hold_pc, hold_inst;
      bit          seen;
      int          k;

      vecs[0] = '{1'b1, 1'b1, 1'b1, RST_PC,           1'b0, 32'd0};
      vecs[1] = '{1'b1, 1'b1, 1'b0, 32'd0,            1'b0, 32'd0};
      vecs[2] = '{1'b1, 1'b1, 1'b0, 32'd0,            1'b1, RST_PC};
      vecs[3] = '{1'b1, 1'b1, 1'b1, 32'h8000_0004,    1'b0, 32'd0};
      vecs[4] = '{1'b1, 1'b1, 1'b0, 32'd0,            1'b0, 32'd0};
      vecs[5] = '{1'b1, 1'b1, 1'b0, 32'd0,            1'b1, 32'h8000_0004};
      vecs[6] = '{1'b1, 1'b1, 1'b1, 32'h8000_0008,    1'b0, 32'd0};
      vecs[7] = '{1'b1, 1'b1, 1'b0, 32'd0,            1'b0, 32'd0};
      vecs[8] = '{1'b1, 1'b1, 1'b0, 32'd0,            1'b1, 32'h8000_0008};

      n_fire = 0; n_cons = 0;
      do_reset();
      chk_b("rst_out_valid", out_valid, 1'b0);
      chk("rst_out_pc", out_pc, 32'd0);
      chk("rst_out_inst", out_inst, 32'd0);
      chk_b("rst_out_err", out_err, 1'b0);
      chk_b("rst_req_valid", req_valid, 1'b1);
      chk("rst_req_addr", req_addr, RST_PC);
      chk("rst_perf_fetch", perf_fetch_cnt, 32'd0);
      chk("rst_perf_wait", perf_wait_cyc, 32'd0);

      // Zero-wait loop: one instruction every 3 cycles
      for (int i = 0; i < 9; i++) begin
         chk_b($sformatf("vec%0d_req_valid", i), req_valid, vecs[i].exp_req_valid);
         if (vecs[i].exp_req_valid) chk($sformatf("vec%0d_req_addr", i), req_addr, vecs[i].exp_req_addr);
         chk_b($sformatf("vec%0d_out_valid", i), out_valid, vecs[i].exp_out_valid);
         if (vecs[i].exp_out_valid) chk($sformatf("vec%0d_out_pc", i), out_pc, vecs[i].exp_out_pc);
         cycle(vecs[i].rr, vecs[i].orr, 1'b0, 32'd0, 0);
      end

      // IDU back-pressure in HOLD
      wait_out(0, "stall");
      hold_pc = out_pc;
      hold_inst = out_inst;
      chk("stall_pc", hold_pc, 32'h8000_000c);
      for (int i = 0; i < 5; i++) begin
         cycle(1'b1, 1'b0, 1'b0, 32'd0, 0);
         chk_b("stall_valid", out_valid, 1'b1);
         chk("stall_out_pc", out_pc, hold_pc);
         chk("stall_out_inst", out_inst, hold_inst);
         chk_b("stall_no_req", req_valid, 1'b0);
      end
      cycle(1'b1, 1'b1, 1'b0, 32'd0, 0);
      chk_b("stall_next_req", req_valid, 1'b1);
      chk("stall_next_addr", req_addr, hold_pc + 32'd4);

      // Redirect while WAIT, before the response
      cycle(1'b1, 1'b0, 1'b0, 32'd0, 2);
      chk_b("wait_no_req", req_valid, 1'b0);
      cycle(1'b0, 1'b0, 1'b1, 32'h8000_1000, 0);
      seen = 1'b0; k = 0;
      while (!out_valid && k < 20) begin
         if (req_valid && !seen) begin
            chk("redir_req_addr", req_addr, 32'h8000_1000);
            seen = 1'b1;
         end
         cycle(1'b1, 1'b0, 1'b0, 32'd0, 0);
         k++;
      end
      chk_b("redir_out_valid", out_valid, 1'b1);
      chk("redir_out_pc", out_pc, 32'h8000_1000);
      cycle(1'b1, 1'b1, 1'b0, 32'd0, 0);

      // Bus error at 80000010, then misaligned redirect
      do_reset();
      k = 0;
      wait_out(0, "err_seek");
      while (out_pc != 32'h8000_0010 && k < 10) begin
         cycle(1'b1, 1'b1, 1'b0, 32'd0, 0);
         wait_out(0, "err_seek");
         k++;
      end
      chk("err_out_pc", out_pc, 32'h8000_0010);
      chk_b("err_out_err", out_err, 1'b1);
      chk("err_out_inst", out_inst, mem_word(32'h8000_0010));
      cycle(1'b1, 1'b0, 1'b1, 32'h8000_0102, 0);
      chk_b("mis_out_valid0", out_valid, 1'b0);
      chk_b("mis_no_req", req_valid, 1'b0);
      cycle(1'b1, 1'b0, 1'b0, 32'd0, 0);
      chk_b("mis_out_valid", out_valid, 1'b1);
      chk_b("mis_out_err", out_err, 1'b1);
      chk("mis_out_inst", out_inst, 32'd0);
      chk("mis_out_pc", out_pc, 32'h8000_0102);
      chk_b("mis_no_req2", req_valid, 1'b0);
      cycle(1'b1, 1'b0, 1'b1, RST_PC, 0);

      // Reset asserted while WAIT; stale response must be ignored
      do_reset();
      cycle(1'b1, 1'b0, 1'b0, 32'd0, 1);
      rst = 1'b0; req_ready = 1'b0; redirect_valid = 1'b0; rsp_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      chk_b("rstw_out_valid", out_valid, 1'b0);
      chk_b("rstw_req_valid", req_valid, 1'b1);
      chk("rstw_req_addr", req_addr, RST_PC);
      rsp_valid = 1'b1; rsp_data = 32'hdead_beef; rsp_err = 1'b1; req_ready = 1'b0;
      @(posedge clk); #1;
      rsp_valid = 1'b0;
      chk_b("stale_out_valid", out_valid, 1'b0);
      chk_b("stale_req_valid", req_valid, 1'b1);
      chk("stale_req_addr", req_addr, RST_PC);
      mem_busy = 1'b0; model_pc = RST_PC;
      wait_out(0, "rstw_fetch");
      chk("rstw_out_pc", out_pc, RST_PC);
      chk("rstw_out_inst", out_inst, mem_word(RST_PC));
      cycle(1'b1, 1'b1, 1'b0, 32'd0, 0);

      // Random traffic against the PC-level model
      do_reset();
      n_cons = 0;
      for (int i = 0; i < 3000; i++) begin
         logic        rv;
         logic [31:0] rpc;
         rv  = ($urandom_range(0, 11) == 0);
         rpc = RST_PC + $urandom_range(0, 63) * 4;
         if ($urandom_range(0, 7) == 0) rpc = rpc + $urandom_range(1, 3);
         cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, rv, rpc, $urandom_range(0, 3));
      end
      chk_b("rand_progress", n_cons > 150, 1'b1);

      // Performance counters: 10 fetches at 2-cycle memory latency
      do_reset();
      chk("perf_clr_fetch", perf_fetch_cnt, 32'd0);
      chk("perf_clr_wait", perf_wait_cyc, 32'd0);
      n_fire = 0; n_cons = 0; k = 0;
      while (n_cons < 10 && k < 200) begin
         cycle(n_fire < 10, 1'b1, 1'b0, 32'd0, 1);
         k++;
      end
      chk("perf_consumed", n_cons, 32'd10);
`ifdef YSYX_24070016_IFETCH_PERF_EN
      chk("perf_fetch_cnt", perf_fetch_cnt, 32'd10);
      chk("perf_wait_cyc", perf_wait_cyc, 32'd20);
`else
      chk("perf_fetch_cnt", perf_fetch_cnt, 32'd0);
      chk("perf_wait_cyc", perf_wait_cyc, 32'd0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
